// File: rtl/monopix_pkg.sv
// Shared types and helpers for the MONOPIX hit decoder.
package monopix_pkg;

    // Raw hit record from the serial-readout receiver; le/te are gray-coded.
    typedef struct packed {
        logic [5:0] col;
        logic [8:0] row;
        logic [5:0] le;
        logic [5:0] te;
    } t_data;

    // Decoded record held in the stage-1 register.
    typedef struct packed {
        logic [5:0] col;
        logic [8:0] row;
        logic [5:0] le_b;
        logic [5:0] tot;
    } t_s1;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_OVERFLOW = 1'b1
    } t_state;

    localparam logic [1:0] WORD_HIT  = 2'b00;
    localparam logic [1:0] WORD_LOST = 2'b01;

    // Gray to binary: each bit is the xor of itself and all higher gray bits.
    function automatic logic [5:0] gray2bin6(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Time over threshold; the 6-bit subtraction wraps naturally mod 64.
    function automatic logic [5:0] tot6(input logic [5:0] le_b, input logic [5:0] te_b);
        return te_b - le_b;
    endfunction

endpackage

// File: rtl/monopix_hit_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a separate counter.
module monopix_hit_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    // Full blocks a write even when a pop happens in the same cycle.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; cleared asynchronously so contents vanish at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/monopix_hit_decoder.sv
// MONOPIX hit decoder: gray-decode LE/TE, compute ToT, pack into a FIFO,
// replace dropped hits with a lost-hit marker word.
// Optional build macro MONOPIX_TOT_FILTER_EN adds a static ToT threshold
// (tot_min) and a saturating count of filtered hits (filt_cnt).
module monopix_hit_decoder
    import monopix_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LOST_W     = 16
) (
    input  logic                          clk_out,
    input  logic                          rst_n,
    input  logic [26:0]                   hit_data,
    input  logic                          hit_strobe,
`ifdef MONOPIX_TOT_FILTER_EN
    input  logic [5:0]                    tot_min,
    output logic [15:0]                   filt_cnt,
`endif
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          lost_pending
);
    localparam int STAGES = 1;
    localparam logic [LOST_W-1:0] LOST_MAX = '1;
    localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

    t_data               hit_in;
    t_s1                 s1;
    logic [STAGES:1]     vld_q;
    logic [STAGES:0]     vld_pipe;
    logic                s1_hit;
    t_state              state;
    logic [LOST_W-1:0]   lost_cnt;
    logic [15:0]         lost_ext;
    logic [31:0]         hit_word;
    logic [31:0]         lost_word;
    logic                wr_en;
    logic [31:0]         wr_data;
    logic                full;
    logic                empty;
    logic [31:0]         rd_data;

    assign hit_in   = hit_data;
    assign vld_pipe = {vld_q, hit_strobe};

    // Stage 1: capture and decode the incoming record.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            s1    <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (hit_strobe) begin
                s1.col  <= hit_in.col;
                s1.row  <= hit_in.row;
                s1.le_b <= gray2bin6(hit_in.le);
                s1.tot  <= tot6(gray2bin6(hit_in.le), gray2bin6(hit_in.te));
            end
        end
    end

`ifdef MONOPIX_TOT_FILTER_EN
    logic s1_filt;
    assign s1_filt = vld_pipe[STAGES] && (s1.tot < tot_min);
    assign s1_hit  = vld_pipe[STAGES] && !s1_filt;

    // Count silently discarded short hits, saturating.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n)                         filt_cnt <= '0;
        else if (s1_filt && filt_cnt != '1) filt_cnt <= filt_cnt + 1'b1;
    end
`else
    assign s1_hit = vld_pipe[STAGES];
`endif

    // Zero-extend the lost counter into the 16-bit marker field.
    always_comb begin
        lost_ext              = '0;
        lost_ext[LOST_W-1:0]  = lost_cnt;
    end

    assign hit_word  = {WORD_HIT, s1.col, s1.row, s1.le_b, s1.tot, 3'b000};
    assign lost_word = {WORD_LOST, 14'd0, lost_ext};

    // Stage 2 write select: a pending marker takes the free slot over any hit.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = hit_word;
        if (state == ST_NORMAL) begin
            wr_en = s1_hit && !full;
        end else if (!full) begin
            wr_en   = 1'b1;
            wr_data = lost_word;
        end
    end

    // Overflow FSM and lost-hit counter.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_NORMAL;
            lost_cnt <= '0;
        end else if (state == ST_NORMAL) begin
            if (s1_hit && full) begin
                lost_cnt <= LOST_ONE;
                state    <= ST_OVERFLOW;
            end
        end else if (full) begin
            if (s1_hit && lost_cnt != LOST_MAX) lost_cnt <= lost_cnt + 1'b1;
        end else if (s1_hit) begin
            // Marker goes out now; this hit is the first of the next batch.
            lost_cnt <= LOST_ONE;
        end else begin
            lost_cnt <= '0;
            state    <= ST_NORMAL;
        end
    end

    monopix_hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk_out),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (out_valid && out_ready),
        .rd_data (rd_data),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign out_valid    = !empty;
    assign out_data     = empty ? 32'd0 : rd_data;
    assign lost_pending = (state == ST_OVERFLOW);

endmodule

// File: tb/tb_monopix_hit_decoder.sv
// Self-checking bench for monopix_hit_decoder: randomized traffic against a
// queue-based reference model plus directed scenarios.
module tb_monopix_hit_decoder;
    localparam int DEPTH    = 16;
    localparam int LOST_MAX = 65535;

    logic        clk_out = 1'b0;
    logic        rst_n;
    logic [26:0] hit_data;
    logic        hit_strobe;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_level;
    logic        lost_pending;
`ifdef MONOPIX_TOT_FILTER_EN
    logic [5:0]  tot_min;
    logic [15:0] filt_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_ovf;
    int          m_lost;
    bit          m_s1_v;
    logic [31:0] m_s1_word;
    int          m_s1_tot;
    int          m_filt;

    always #5 clk_out = ~clk_out;

    monopix_hit_decoder #(.FIFO_DEPTH(DEPTH), .LOST_W(16)) dut (
        .clk_out      (clk_out),
        .rst_n        (rst_n),
        .hit_data     (hit_data),
        .hit_strobe   (hit_strobe),
`ifdef MONOPIX_TOT_FILTER_EN
        .tot_min      (tot_min),
        .filt_cnt     (filt_cnt),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .lost_pending (lost_pending)
    );

    function automatic logic [5:0] gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary = xor of all right shifts of the gray value.
    function automatic int ungray(input logic [5:0] g);
        int b = 0;
        for (int i = 0; i < 6; i++) b = b ^ (int'(g) >> i);
        return b & 63;
    endfunction

    function automatic logic [26:0] mk(input int col, input int row, input int le_b, input int te_b);
        return {6'(col), 9'(row), gray(6'(le_b)), gray(6'(te_b))};
    endfunction

    function automatic logic [31:0] word_of(input int col, input int row, input int le_b, input int tot);
        return 32'((col << 24) | (row << 15) | (le_b << 9) | (tot << 3));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 0;
        m_lost = 0;
        m_s1_v = 0;
        m_filt = 0;
    endtask

    // One clock: drive, check registered outputs against the model, advance the model.
    task automatic cycle(input bit stb, input logic [26:0] d, input bit rdy);
        bit full, pop, hit, push;
        logic [31:0] pw;
        int leb, teb;
        hit_strobe = stb;
        hit_data   = d;
        out_ready  = rdy;
        #1;
        checks++;
        if (out_valid !== (mq.size() != 0)) begin
            failures++; $display("FAIL out_valid: got %b want %b", out_valid, mq.size() != 0);
        end
        checks++;
        if (fifo_level !== 5'(mq.size())) begin
            failures++; $display("FAIL fifo_level: got %0d want %0d", fifo_level, mq.size());
        end
        checks++;
        if (lost_pending !== m_ovf) begin
            failures++; $display("FAIL lost_pending: got %b want %b", lost_pending, m_ovf);
        end
        if (mq.size() > 0) begin
            checks++;
            if (out_data !== mq[0]) begin
                failures++; $display("FAIL out_data: got %h want %h", out_data, mq[0]);
            end
        end
`ifdef MONOPIX_TOT_FILTER_EN
        checks++;
        if (filt_cnt !== 16'(m_filt)) begin
            failures++; $display("FAIL filt_cnt: got %0d want %0d", filt_cnt, m_filt);
        end
`endif
        full = (mq.size() == DEPTH);
        pop  = rdy && (mq.size() > 0);
        hit  = m_s1_v;
        push = 0;
        pw   = '0;
`ifdef MONOPIX_TOT_FILTER_EN
        if (m_s1_v && m_s1_tot < int'(tot_min)) begin
            hit = 0;
            if (m_filt < 65535) m_filt++;
        end
`endif
        if (!m_ovf) begin
            if (hit && !full) begin push = 1; pw = m_s1_word; end
            else if (hit) begin m_lost = 1; m_ovf = 1; end
        end else if (full) begin
            if (hit && m_lost < LOST_MAX) m_lost++;
        end else begin
            push = 1;
            pw   = 32'h4000_0000 | 32'(m_lost);
            if (hit) m_lost = 1;
            else begin m_lost = 0; m_ovf = 0; end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(pw);
        m_s1_v = stb;
        if (stb) begin
            leb       = ungray(d[11:6]);
            teb       = ungray(d[5:0]);
            m_s1_tot  = (teb - leb + 64) % 64;
            m_s1_word = word_of(int'(d[26:21]), int'(d[20:12]), leb, m_s1_tot);
        end
        @(posedge clk_out);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 27'd0, rdy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hit_strobe = 0; hit_data = '0; out_ready = 0;
        repeat (3) @(posedge clk_out);
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 5'd0 || lost_pending !== 1'b0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b level=%0d lost=%b data=%h want all 0",
                     out_valid, fifo_level, lost_pending, out_data);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        cycle(1'b1, mk(5, 100, 10, 17), 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL single_lat1: out_valid=%b want 0", out_valid);
        end
        cycle(1'b0, 27'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0532_1438) begin
            failures++; $display("FAIL single_word: valid=%b data=%h want 1 05321438", out_valid, out_data);
        end
        cycle(1'b0, 27'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL single_pop: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, mk(63, 511, 62, 1), 1'b1);
        cycle(1'b1, mk(0, 0, 0, 0), 1'b1);
        checks++;
        if (out_data !== word_of(63, 511, 62, 3)) begin
            failures++; $display("FAIL wrap_tot3: got %h want %h", out_data, word_of(63, 511, 62, 3));
        end
        cycle(1'b0, 27'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd0) begin
            failures++; $display("FAIL wrap_tot0: valid=%b data=%h want 1 00000000", out_valid, out_data);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 5; i++) cycle(1'b1, 27'($urandom), 1'b0);
        idle(2, 1'b0);
        checks++;
        if (fifo_level !== 5'd16 || lost_pending !== 1'b1) begin
            failures++; $display("FAIL ovf_full: level=%0d lost=%b want 16 1", fifo_level, lost_pending);
        end
        idle(DEPTH, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h4000_0005) begin
            failures++; $display("FAIL ovf_marker: valid=%b data=%h want 1 40000005", out_valid, out_data);
        end
        checks++;
        if (lost_pending !== 1'b0) begin
            failures++; $display("FAIL ovf_clear: lost_pending=%b want 0", lost_pending);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 27'($urandom), 1'b1);
        idle(4, 1'b1);
    endtask

    task automatic test_pop_collide();
        logic [31:0] seen[$];
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 27'($urandom), 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 27'($urandom), 1'b1);
        cycle(1'b0, 27'd0, 1'b0);
        checks++;
        if (lost_pending !== 1'b1 || fifo_level !== 5'd16) begin
            failures++; $display("FAIL collide_state: lost=%b level=%0d want 1 16", lost_pending, fifo_level);
        end
        cycle(1'b0, 27'd0, 1'b1);
        idle(2, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (out_valid) seen.push_back(out_data);
            cycle(1'b0, 27'd0, 1'b1);
        end
        checks++;
        if (seen.size() != 16 || seen[14] !== 32'h4000_0002 || seen[15] !== 32'h4000_0001) begin
            failures++;
            $display("FAIL collide_markers: n=%0d last=%h,%h want 16 40000002,40000001",
                     seen.size(), (seen.size() > 1) ? seen[seen.size()-2] : 32'h0,
                     (seen.size() > 0) ? seen[seen.size()-1] : 32'h0);
        end
    endtask

    task automatic test_random();
        int pstb, prdy;
        for (int ph = 0; ph < 6; ph++) begin
            pstb = $urandom_range(30, 100);
            prdy = $urandom_range(10, 100);
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(0, 99) < pstb, 27'($urandom), $urandom_range(0, 99) < prdy);
        end
        idle(40, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH / 2; i++) cycle(1'b1, 27'($urandom), 1'b0);
        hit_strobe = 1'b1;
        hit_data   = 27'($urandom);
        rst_n      = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 5'd0 || lost_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b level=%0d lost=%b want 0 0 0", out_valid, fifo_level, lost_pending);
        end
        hit_strobe = 1'b0;
        repeat (2) @(posedge clk_out);
        #1;
        rst_n = 1'b1;
        model_reset();
        test_single();
    endtask

`ifdef MONOPIX_TOT_FILTER_EN
    task automatic test_filter();
        int n = 0;
        logic [31:0] w = '0;
        tot_min = 6'd4;
        cycle(1'b1, mk(1, 2, 20, 23), 1'b1);
        cycle(1'b1, mk(3, 4, 20, 24), 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (out_valid) begin n++; w = out_data; end
            cycle(1'b0, 27'd0, 1'b1);
        end
        checks++;
        if (n != 1 || w !== word_of(3, 4, 20, 4) || filt_cnt !== 16'd1 || lost_pending !== 1'b0) begin
            failures++;
            $display("FAIL filter: words=%0d last=%h filt=%0d lost=%b want 1 %h 1 0",
                     n, w, filt_cnt, lost_pending, word_of(3, 4, 20, 4));
        end
        tot_min = 6'd0;
    endtask
`endif

    initial begin
`ifdef MONOPIX_TOT_FILTER_EN
        tot_min = 6'd0;
`endif
        test_reset();
        test_single();
        test_wrap();
        test_overflow();
        test_pop_collide();
        test_random();
        test_reset_mid();
`ifdef MONOPIX_TOT_FILTER_EN
        test_filter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
